// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by the fetch (IF) and memory (ME) pipeline stages.
// Each access runs IDLE -> MEM -> RESP, with store lane steering and load extension.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_W      = 32,
  parameter int unsigned IF_MAX_WAIT = 4,
  parameter int unsigned MEM_OP_W    = 4
) (
  input  logic                clk,
  input  logic                clr_n,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_ack,
  output logic [WORD_W-1:0]   o_if_rdata,
  output logic                o_if_busy,
  input  logic                i_me_req,
  input  logic [MEM_OP_W-1:0] i_me_op,
  input  logic [ADDR_W-1:0]   i_me_addr,
  input  logic [WORD_W-1:0]   i_me_wdata,
  output logic                o_me_ack,
  output logic [WORD_W-1:0]   o_me_rdata,
  output logic                o_me_misalign,
  output logic                o_me_busy,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [3:0]          o_mem_wstrb,
  output logic [WORD_W-1:0]   o_mem_wdata,
  input  logic                i_mem_ready,
  input  logic [WORD_W-1:0]   i_mem_rdata
);

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE     = MEM_OP_W'(0);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = MEM_OP_W'(1);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = MEM_OP_W'(2);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = MEM_OP_W'(3);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UBYTE = MEM_OP_W'(4);
  localparam logic [MEM_OP_W-1:0] MEM_OP_RD_UHALF = MEM_OP_W'(5);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = MEM_OP_W'(6);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = MEM_OP_W'(7);
  localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = MEM_OP_W'(8);

  localparam logic [3:0] MaxWait = 4'(IF_MAX_WAIT);

  typedef enum logic [1:0] {StIdle, StMem, StResp} state_e;

  state_e                state_q, state_d;
  logic                  gnt_if_q, gnt_if_d;
  logic [MEM_OP_W-1:0]   op_q, op_d;
  logic [1:0]            lane_q, lane_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [3:0]            mem_wstrb_q, mem_wstrb_d;
  logic [WORD_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  if_ack_q, if_ack_d;
  logic [WORD_W-1:0]     if_rdata_q, if_rdata_d;
  logic                  me_ack_q, me_ack_d;
  logic [WORD_W-1:0]     me_rdata_q, me_rdata_d;
  logic                  me_misalign_q, me_misalign_d;

  logic [1:0]            me_lane;
  logic                  me_is_load, me_is_store, me_mis;
  logic [3:0]            me_wstrb;
  logic [WORD_W-1:0]     me_wdata;
  logic                  grant_if, grant_me;
  logic [3:0]            cnt_inc;
  logic [WORD_W-1:0]     shifted, load_ext;
  logic                  unused_if_lane;

  assign unused_if_lane = ^i_if_addr[1:0];
  assign me_lane        = i_me_addr[1:0];

  // Decode the ME op: alignment, store strobes and lane-replicated data.
  always_comb begin
    me_is_load  = 1'b0;
    me_is_store = 1'b0;
    me_mis      = 1'b0;
    me_wstrb    = 4'b0000;
    me_wdata    = '0;
    case (i_me_op)
      MEM_OP_RD_BYTE, MEM_OP_RD_UBYTE: me_is_load = 1'b1;
      MEM_OP_RD_HALF, MEM_OP_RD_UHALF: begin
        me_is_load = 1'b1;
        me_mis     = i_me_addr[0];
      end
      MEM_OP_RD_WORD: begin
        me_is_load = 1'b1;
        me_mis     = |i_me_addr[1:0];
      end
      MEM_OP_WR_BYTE: begin
        me_is_store = 1'b1;
        me_wstrb    = 4'b0001 << me_lane;
        me_wdata    = {4{i_me_wdata[7:0]}};
      end
      MEM_OP_WR_HALF: begin
        me_is_store = 1'b1;
        me_mis      = i_me_addr[0];
        me_wstrb    = 4'b0011 << me_lane;
        me_wdata    = {2{i_me_wdata[15:0]}};
      end
      MEM_OP_WR_WORD: begin
        me_is_store = 1'b1;
        me_mis      = |i_me_addr[1:0];
        me_wstrb    = 4'b1111;
        me_wdata    = i_me_wdata;
      end
      default: ;
    endcase
  end

  // IF only beats a pending ME request once it has been passed over MaxWait times.
  assign grant_if = i_if_req & (~i_me_req | (cnt_q == MaxWait));
  assign grant_me = i_me_req & ~grant_if;
  assign cnt_inc  = (cnt_q == MaxWait) ? cnt_q : cnt_q + 4'd1;

  always_comb begin
    shifted  = i_mem_rdata >> {lane_q, 3'b000};
    load_ext = '0;
    case (op_q)
      MEM_OP_RD_BYTE:  load_ext = {{(WORD_W-8){shifted[7]}}, shifted[7:0]};
      MEM_OP_RD_UBYTE: load_ext = {{(WORD_W-8){1'b0}}, shifted[7:0]};
      MEM_OP_RD_HALF:  load_ext = {{(WORD_W-16){shifted[15]}}, shifted[15:0]};
      MEM_OP_RD_UHALF: load_ext = {{(WORD_W-16){1'b0}}, shifted[15:0]};
      MEM_OP_RD_WORD:  load_ext = shifted;
      default:         load_ext = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    gnt_if_d      = gnt_if_q;
    op_d          = op_q;
    lane_d        = lane_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wstrb_d   = mem_wstrb_q;
    mem_wdata_d   = mem_wdata_q;
    if_ack_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    me_ack_d      = 1'b0;
    me_rdata_d    = me_rdata_q;
    me_misalign_d = me_misalign_q;
    unique case (state_q)
      StIdle: begin
        if (grant_if) begin
          gnt_if_d    = 1'b1;
          cnt_d       = 4'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {i_if_addr[ADDR_W-1:2], 2'b00};
          mem_wstrb_d = 4'b0000;
          mem_wdata_d = '0;
          state_d     = StMem;
        end else if (grant_me) begin
          gnt_if_d = 1'b0;
          op_d     = i_me_op;
          lane_d   = me_lane;
          cnt_d    = i_if_req ? cnt_inc : 4'd0;
          if ((me_is_load | me_is_store) & ~me_mis) begin
            mem_req_d   = 1'b1;
            mem_we_d    = me_is_store;
            mem_addr_d  = {i_me_addr[ADDR_W-1:2], 2'b00};
            mem_wstrb_d = me_wstrb;
            mem_wdata_d = me_wdata;
            state_d     = StMem;
          end else begin
            me_ack_d      = 1'b1;
            me_rdata_d    = '0;
            me_misalign_d = me_mis;
            state_d       = StResp;
          end
        end else begin
          cnt_d = 4'd0;
        end
      end
      StMem: begin
        if (i_mem_ready) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'b0000;
          state_d     = StResp;
          if (gnt_if_q) begin
            if_ack_d   = 1'b1;
            if_rdata_d = i_mem_rdata;
          end else begin
            me_ack_d      = 1'b1;
            me_rdata_d    = load_ext;
            me_misalign_d = 1'b0;
          end
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q       <= StIdle;
      gnt_if_q      <= 1'b0;
      op_q          <= '0;
      lane_q        <= 2'b00;
      cnt_q         <= 4'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wstrb_q   <= 4'b0000;
      mem_wdata_q   <= '0;
      if_ack_q      <= 1'b0;
      if_rdata_q    <= '0;
      me_ack_q      <= 1'b0;
      me_rdata_q    <= '0;
      me_misalign_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_if_q      <= gnt_if_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wstrb_q   <= mem_wstrb_d;
      mem_wdata_q   <= mem_wdata_d;
      if_ack_q      <= if_ack_d;
      if_rdata_q    <= if_rdata_d;
      me_ack_q      <= me_ack_d;
      me_rdata_q    <= me_rdata_d;
      me_misalign_q <= me_misalign_d;
    end
  end

  assign o_if_ack      = if_ack_q;
  assign o_if_rdata    = if_rdata_q;
  assign o_if_busy     = i_if_req & ~if_ack_q;
  assign o_me_ack      = me_ack_q;
  assign o_me_rdata    = me_rdata_q;
  assign o_me_misalign = me_misalign_q;
  assign o_me_busy     = i_me_req & ~me_ack_q;
  assign o_mem_req     = mem_req_q;
  assign o_mem_we      = mem_we_q;
  assign o_mem_addr    = mem_addr_q;
  assign o_mem_wstrb   = mem_wstrb_q;
  assign o_mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a queue of expected responses is filled as requests are issued
// and drained by a monitor on every ack; per-feature tasks check the memory-side signals.
module tb_mem_port_arbiter;

  localparam logic [3:0] OP_NONE     = 4'd0;
  localparam logic [3:0] OP_RD_BYTE  = 4'd1;
  localparam logic [3:0] OP_RD_HALF  = 4'd2;
  localparam logic [3:0] OP_RD_WORD  = 4'd3;
  localparam logic [3:0] OP_RD_UBYTE = 4'd4;
  localparam logic [3:0] OP_RD_UHALF = 4'd5;
  localparam logic [3:0] OP_WR_BYTE  = 4'd6;
  localparam logic [3:0] OP_WR_HALF  = 4'd7;
  localparam logic [3:0] OP_WR_WORD  = 4'd8;

  logic        clk, clr_n;
  logic        i_if_req, o_if_ack, o_if_busy;
  logic [31:0] i_if_addr, o_if_rdata;
  logic        i_me_req, o_me_ack, o_me_misalign, o_me_busy;
  logic [3:0]  i_me_op;
  logic [31:0] i_me_addr, i_me_wdata, o_me_rdata;
  logic        o_mem_req, o_mem_we, i_mem_ready;
  logic [31:0] o_mem_addr, o_mem_wdata, i_mem_rdata;
  logic [3:0]  o_mem_wstrb;

  mem_port_arbiter #(
    .ADDR_W(32), .WORD_W(32), .IF_MAX_WAIT(4), .MEM_OP_W(4)
  ) dut (
    .clk(clk), .clr_n(clr_n),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_ack(o_if_ack),
    .o_if_rdata(o_if_rdata), .o_if_busy(o_if_busy),
    .i_me_req(i_me_req), .i_me_op(i_me_op), .i_me_addr(i_me_addr), .i_me_wdata(i_me_wdata),
    .o_me_ack(o_me_ack), .o_me_rdata(o_me_rdata), .o_me_misalign(o_me_misalign),
    .o_me_busy(o_me_busy),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wstrb(o_mem_wstrb), .o_mem_wdata(o_mem_wdata),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_if;
    logic [31:0] rdata;
    logic        mis;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          mem_wait = 0;
  logic [31:0] mem_word = 32'h0;

  // Memory-side captures from the latest ME access
  logic        seen_req, seen_we;
  logic [31:0] seen_addr, seen_wdata;
  logic [3:0]  seen_wstrb;

  // Memory model: raises ready after mem_wait stalled MEM cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    i_mem_ready = 1'b0;
    i_mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (o_mem_req) begin
        if (wcnt >= mem_wait) begin
          i_mem_ready = 1'b1;
          i_mem_rdata = mem_word;
        end else begin
          i_mem_ready = 1'b0;
          i_mem_rdata = 32'h0;
          wcnt++;
        end
      end else begin
        i_mem_ready = 1'b0;
        i_mem_rdata = 32'h0;
        wcnt = 0;
      end
    end
  end

  // Response monitor: every ack pops and checks one scoreboard entry.
  initial begin
    exp_t        e;
    logic [31:0] rd;
    logic        mis;
    forever begin
      @(negedge clk);
      if (o_if_ack || o_me_ack) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: if_ack=%b me_ack=%b, required no ack", o_if_ack,
                   o_me_ack);
        end else begin
          e   = sb.pop_front();
          rd  = o_if_ack ? o_if_rdata : o_me_rdata;
          mis = o_if_ack ? 1'b0 : o_me_misalign;
          if ((o_if_ack && o_me_ack) || (o_if_ack !== e.is_if) || (rd !== e.rdata) ||
              (mis !== e.mis)) begin
            miscompares++;
            $display("FAIL response: got if=%b me=%b rdata=%h mis=%b, required if=%b rdata=%h mis=%b",
                     o_if_ack, o_me_ack, rd, mis, e.is_if, e.rdata, e.mis);
          end
        end
      end
    end
  end

  task automatic me_access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input int wt, input logic [31:0] word, input logic [31:0] exp_rd,
                           input logic exp_mis, input int exp_lat, input string name);
    int lat;
    bit got;
    mem_wait = wt;
    mem_word = word;
    sb.push_back(exp_t'{is_if: 1'b0, rdata: exp_rd, mis: exp_mis});
    @(posedge clk); #1;
    i_me_req = 1'b1; i_me_op = op; i_me_addr = addr; i_me_wdata = wd;
    seen_req = 1'b0; seen_we = 1'b0; seen_addr = '0; seen_wdata = '0; seen_wstrb = '0;
    got = 1'b0; lat = -1;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (o_mem_req && !seen_req) begin
        seen_req = 1'b1; seen_we = o_mem_we; seen_addr = o_mem_addr;
        seen_wdata = o_mem_wdata; seen_wstrb = o_mem_wstrb;
      end
      if (o_me_ack) begin
        got = 1'b1;
        lat = c;
      end
    end
    vectors++;
    if (!got || lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
      if (!got) sb.delete();
    end
    vectors++;
    if (seen_req !== (exp_lat > 1)) begin
      miscompares++;
      $display("FAIL %s mem_req_seen: got %b, required %b", name, seen_req, exp_lat > 1);
    end
    @(posedge clk); #1;
    i_me_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [167:0] outs;
    #1;
    outs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata, o_if_ack, o_if_rdata,
            o_me_ack, o_me_rdata, o_me_misalign, o_if_busy, o_me_busy};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_if_read();
    mem_wait = 0;
    mem_word = 32'hDEADBEEF;
    sb.push_back(exp_t'{is_if: 1'b1, rdata: 32'hDEADBEEF, mis: 1'b0});
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h100;
    @(negedge clk);
    vectors++;
    if (o_if_busy !== 1'b1 || o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL if_cycle0: busy=%b mem_req=%b, required 1 0", o_if_busy, o_mem_req);
    end
    @(negedge clk);
    vectors++;
    if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100 || o_mem_we !== 1'b0 ||
        o_mem_wstrb !== 4'b0000 || o_if_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL if_cycle1: req=%b addr=%h we=%b wstrb=%b busy=%b, required 1 100 0 0000 1",
               o_mem_req, o_mem_addr, o_mem_we, o_mem_wstrb, o_if_busy);
    end
    @(negedge clk);
    vectors++;
    if (o_if_ack !== 1'b1 || o_if_busy !== 1'b0 || o_mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL if_cycle2: ack=%b busy=%b mem_req=%b, required 1 0 0", o_if_ack, o_if_busy,
               o_mem_req);
    end
    @(posedge clk); #1;
    i_if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_loads();
    me_access(OP_RD_BYTE,  32'h203, 32'h0, 3, 32'h80FF0011, 32'hFFFFFF80, 1'b0, 5, "rd_byte_203");
    vectors++;
    if (seen_addr !== 32'h200 || seen_we !== 1'b0 || seen_wstrb !== 4'b0000) begin
      miscompares++;
      $display("FAIL rd_byte_mem: addr=%h we=%b wstrb=%b, required 200 0 0000", seen_addr,
               seen_we, seen_wstrb);
    end
    me_access(OP_RD_UBYTE, 32'h203, 32'h0, 3, 32'h80FF0011, 32'h00000080, 1'b0, 5, "rd_ubyte_203");
    me_access(OP_RD_HALF,  32'h202, 32'h0, 0, 32'h80FF0011, 32'hFFFF80FF, 1'b0, 2, "rd_half_202");
    me_access(OP_RD_UHALF, 32'h202, 32'h0, 1, 32'h80FF0011, 32'h000080FF, 1'b0, 3, "rd_uhalf_202");
    me_access(OP_RD_BYTE,  32'h202, 32'h0, 0, 32'h80FF0011, 32'hFFFFFFFF, 1'b0, 2, "rd_byte_202");
    me_access(OP_RD_HALF,  32'h200, 32'h0, 0, 32'h80FF0011, 32'h00000011, 1'b0, 2, "rd_half_200");
    me_access(OP_RD_WORD,  32'h204, 32'h0, 0, 32'h80FF0011, 32'h80FF0011, 1'b0, 2, "rd_word_204");
  endtask

  task automatic test_stores();
    logic [31:0] sa [3] = '{32'h12, 32'h21, 32'h30};
    logic [3:0]  so [3] = '{OP_WR_HALF, OP_WR_BYTE, OP_WR_WORD};
    logic [31:0] sd [3] = '{32'h0000ABCD, 32'h123456EF, 32'hCAFEF00D};
    logic [31:0] ea [3] = '{32'h10, 32'h20, 32'h30};
    logic [3:0]  es [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ed [3] = '{32'hABCDABCD, 32'hEFEFEFEF, 32'hCAFEF00D};
    for (int i = 0; i < 3; i++) begin
      me_access(so[i], sa[i], sd[i], 0, 32'h5A5A5A5A, 32'h0, 1'b0, 2, "store");
      vectors++;
      if (seen_addr !== ea[i] || seen_we !== 1'b1 || seen_wstrb !== es[i] ||
          seen_wdata !== ed[i]) begin
        miscompares++;
        $display("FAIL store_%0d: addr=%h we=%b wstrb=%b wdata=%h, required %h 1 %b %h", i,
                 seen_addr, seen_we, seen_wstrb, seen_wdata, ea[i], es[i], ed[i]);
      end
    end
  endtask

  task automatic test_misalign();
    me_access(OP_RD_WORD, 32'h42, 32'h0, 0, 32'h11223344, 32'h0, 1'b1, 1, "mis_rd_word_42");
    me_access(OP_RD_HALF, 32'h41, 32'h0, 0, 32'h11223344, 32'h0, 1'b1, 1, "mis_rd_half_41");
    me_access(OP_WR_WORD, 32'h46, 32'hFFFF, 0, 32'h11223344, 32'h0, 1'b1, 1, "mis_wr_word_46");
    me_access(OP_WR_HALF, 32'h43, 32'hFFFF, 0, 32'h11223344, 32'h0, 1'b1, 1, "mis_wr_half_43");
    me_access(OP_RD_BYTE, 32'h43, 32'h0, 0, 32'h11223344, 32'h00000011, 1'b0, 2, "rd_byte_43");
    me_access(OP_NONE, 32'h40, 32'h0, 0, 32'h11223344, 32'h0, 1'b0, 1, "op_none");
  endtask

  task automatic test_arbitration();
    bit done;
    mem_wait = 0;
    mem_word = 32'h12345678;
    for (int i = 0; i < 10; i++)
      sb.push_back(exp_t'{is_if: (i % 5 == 4), rdata: 32'h12345678, mis: 1'b0});
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h402;
    i_me_req = 1'b1; i_me_op = OP_RD_WORD; i_me_addr = 32'h300; i_me_wdata = 32'h0;
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL arbitration_timeout: %0d responses outstanding, required 0", sb.size());
      sb.delete();
    end
    @(posedge clk); #1;
    i_if_req = 1'b0; i_me_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_mem();
    logic [166:0] outs;
    bit           seen, bad;
    mem_wait = 100;
    @(posedge clk); #1;
    i_if_req = 1'b1; i_if_addr = 32'h500;
    seen = 1'b0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clk);
      if (o_mem_req) seen = 1'b1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL mid_mem_req: got 0, required 1");
    end
    #1;
    clr_n = 1'b0;
    #1;
    outs = {o_mem_req, o_mem_we, o_mem_addr, o_mem_wstrb, o_mem_wdata, o_if_ack, o_if_rdata,
            o_me_ack, o_me_rdata, o_me_misalign, o_me_busy};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_mem: got %h, required 0", outs);
    end
    i_if_req = 1'b0;
    mem_wait = 0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (o_mem_req || o_if_ack || o_me_ack) bad = 1'b1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL post_reset_idle: activity seen, required none");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_n = 1'b0;
    i_if_req = 1'b0; i_if_addr = '0;
    i_me_req = 1'b0; i_me_op = OP_NONE; i_me_addr = '0; i_me_wdata = '0;
    test_reset();
    test_if_read();
    test_loads();
    test_stores();
    test_misalign();
    test_arbitration();
    test_reset_mid_mem();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
